// File: rtl/split_arrays.sv
// split_arrays: pops 2*INPUT_ARR_LEN bytes from a FWFT FIFO, writes the first half to L, the second to R, then pulses merge_start
module split_arrays #(
   parameter int INPUT_ARR_LEN = 2,
   parameter int VAR_LEN       = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_empty,
   output logic       rd_in,
   input  logic       afull_L,
   input  logic       afull_R,
   output logic [7:0] array_L,
   output logic [7:0] array_R,
   output logic [1:0] wr_fifo,
   output logic       busy,
   output logic       merge_start
);
   typedef enum logic [1:0] {IDLE, FILL_L, FILL_R, DONE} state_t;
   localparam logic [VAR_LEN-1:0] LAST = VAR_LEN'(INPUT_ARR_LEN - 1);
   state_t state_q, state_d;
   logic [VAR_LEN-1:0] cnt_q, cnt_d;
   logic [7:0] array_l_q, array_l_d, array_r_q, array_r_d;
   logic [1:0] wr_q, wr_d;
   logic ms_q, ms_d;
   logic xfer, last;
   assign xfer = !in_empty && ((state_q == FILL_L && !afull_L) || (state_q == FILL_R && !afull_R));
   assign last = cnt_q == LAST;
   assign rd_in = xfer;
   assign busy = state_q != IDLE;
   assign array_L = array_l_q;
   assign array_R = array_r_q;
   assign wr_fifo = wr_q;
   assign merge_start = ms_q;
   // next state: a byte moves only when the source has data and the target half has room
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      array_l_d = array_l_q;
      array_r_d = array_r_q;
      wr_d = 2'b00;
      ms_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            state_d = start ? FILL_L : IDLE;
         end
         FILL_L: if (xfer) begin
            array_l_d = in_data;
            wr_d = 2'b01;
            cnt_d = last ? '0 : cnt_q + 1'b1;
            state_d = last ? FILL_R : FILL_L;
         end
         FILL_R: if (xfer) begin
            array_r_d = in_data;
            wr_d = 2'b10;
            cnt_d = last ? '0 : cnt_q + 1'b1;
            state_d = last ? DONE : FILL_R;
         end
         default: begin
            ms_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   // state and output registers; async reset abandons any partial split without merge_start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         array_l_q <= '0;
         array_r_q <= '0;
         wr_q <= 2'b00;
         ms_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         array_l_q <= array_l_d;
         array_r_q <= array_r_d;
         wr_q <= wr_d;
         ms_q <= ms_d;
      end
   end
endmodule

// File: tb/tb_split_arrays.sv
// tb_split_arrays: randomized and directed checks of split_arrays against a FIFO-level reference model
module tb_split_arrays;
   logic clk = 0, rst_n = 0, start = 0, start3 = 0, hold_empty = 0, afull_L = 0, afull_R = 0, flush = 0;
   logic [7:0] mem[16], mem3[16];
   logic [3:0] rp = 0, wp = 0, rp3 = 0, wp3 = 0;
   logic [7:0] in_data, in_data3, array_L, array_R, array_L3, array_R3;
   logic in_empty, in_empty3, rd_in, rd3, busy, busy3, merge_start, merge3;
   logic [1:0] wr_fifo, wr3;
   logic [7:0] obsL[$], obsR[$];
   logic [7:0] bytes[6];
   int errors = 0, checks = 0, merges = 0, viol = 0;
   assign in_empty = (rp == wp) | hold_empty;
   assign in_data = mem[rp];
   assign in_empty3 = rp3 == wp3;
   assign in_data3 = mem3[rp3];
   always #5 clk = ~clk;
   split_arrays dut (.clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_empty(in_empty),
      .rd_in(rd_in), .afull_L(afull_L), .afull_R(afull_R), .array_L(array_L), .array_R(array_R),
      .wr_fifo(wr_fifo), .busy(busy), .merge_start(merge_start));
   split_arrays #(.INPUT_ARR_LEN(3), .VAR_LEN(2)) dut3 (.clk(clk), .rst_n(rst_n), .start(start3),
      .in_data(in_data3), .in_empty(in_empty3), .rd_in(rd3), .afull_L(1'b0), .afull_R(1'b0),
      .array_L(array_L3), .array_R(array_R3), .wr_fifo(wr3), .busy(busy3), .merge_start(merge3));
   // input FIFO model: pops on rd_in
   always @(posedge clk) begin
      if (flush) rp <= wp;
      else if (rd_in) rp <= rp + 4'd1;
      if (rd3) rp3 <= rp3 + 4'd1;
   end
   // output FIFO model: collect every strobed byte and flag protocol violations
   always @(negedge clk) begin
      if (wr_fifo[0]) obsL.push_back(array_L);
      if (wr_fifo[1]) obsR.push_back(array_R);
      if (wr3[0]) obsL.push_back(array_L3);
      if (wr3[1]) obsR.push_back(array_R3);
      if (merge_start || merge3) merges++;
      if (wr_fifo == 2'b11 || wr3 == 2'b11) viol++;
      if (rd_in && (in_empty || !busy)) viol++;
      if (rd3 && (in_empty3 || !busy3)) viol++;
   end
   function automatic logic [55:0] got_half(input bit r);
      logic [55:0] v = '0;
      int n = r ? obsR.size() : obsL.size();
      for (int i = 0; i < n; i++) v[47:0] = {v[39:0], r ? obsR[i] : obsL[i]};
      v[55:48] = 8'(n);
      return v;
   endfunction
   function automatic logic [55:0] ref_half(input int n, input bit r);
      logic [55:0] v = '0;
      for (int i = 0; i < n; i++) v[47:0] = {v[39:0], bytes[int'(r) * n + i]};
      v[55:48] = 8'(n);
      return v;
   endfunction
   task automatic clear();
      obsL.delete();
      obsR.delete();
      merges = 0;
      viol = 0;
   endtask
   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wp] = bytes[i];
         wp = wp + 4'd1;
      end
   endtask
   task automatic run(input int ef, input int el, input int rf, input int rl, input int sa, input bit rnd, output int lat);
      int n = 0;
      lat = -1;
      start = 1;
      while (n < 200) begin
         @(posedge clk);
         n++;
         #1;
         start = n == sa;
         hold_empty = (n >= ef && n < ef + el) || (rnd && $urandom_range(3) == 0);
         afull_R = (n >= rf && n < rf + rl) || (rnd && $urandom_range(3) == 0);
         afull_L = rnd && $urandom_range(3) == 0;
         if (merge_start) begin
            lat = n;
            break;
         end
      end
      start = 0;
      hold_empty = 0;
      afull_L = 0;
      afull_R = 0;
      @(negedge clk);
      #1;
   endtask
   task automatic test_reset();
      #3;
      checks++; if (array_L !== 8'h00) begin errors++; $display("FAIL reset_array_L got %h want 00", array_L); end
      checks++; if (array_R !== 8'h00) begin errors++; $display("FAIL reset_array_R got %h want 00", array_R); end
      checks++; if (wr_fifo !== 2'b00) begin errors++; $display("FAIL reset_wr_fifo got %b want 00", wr_fifo); end
      checks++; if (merge_start !== 1'b0) begin errors++; $display("FAIL reset_merge_start got %b want 0", merge_start); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (rd_in !== 1'b0) begin errors++; $display("FAIL reset_rd_in got %b want 0", rd_in); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask
   task automatic test_basic();
      int lat;
      bytes = '{8'h03, 8'h07, 8'h01, 8'h09, 8'h00, 8'h00};
      clear();
      load(4);
      run(0, 0, 0, 0, 0, 0, lat);
      checks++; if (got_half(0) !== ref_half(2, 0)) begin errors++; $display("FAIL basic_L got %h want %h", got_half(0), ref_half(2, 0)); end
      checks++; if (got_half(1) !== ref_half(2, 1)) begin errors++; $display("FAIL basic_R got %h want %h", got_half(1), ref_half(2, 1)); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d want 6", lat); end
      checks++; if (merges !== 1) begin errors++; $display("FAIL basic_merges got %0d want 1", merges); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL basic_protocol got %0d want 0", viol); end
   endtask
   task automatic test_underflow();
      int lat;
      bytes = '{8'h03, 8'h07, 8'h01, 8'h09, 8'h00, 8'h00};
      clear();
      load(4);
      run(3, 3, 0, 0, 0, 0, lat);
      checks++; if (got_half(0) !== ref_half(2, 0)) begin errors++; $display("FAIL underflow_L got %h want %h", got_half(0), ref_half(2, 0)); end
      checks++; if (got_half(1) !== ref_half(2, 1)) begin errors++; $display("FAIL underflow_R got %h want %h", got_half(1), ref_half(2, 1)); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL underflow_latency got %0d want 9", lat); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL underflow_protocol got %0d want 0", viol); end
   endtask
   task automatic test_backpressure();
      int lat;
      bytes = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h00, 8'h00};
      clear();
      load(4);
      run(0, 0, 3, 2, 0, 0, lat);
      checks++; if (got_half(0) !== ref_half(2, 0)) begin errors++; $display("FAIL backpressure_L got %h want %h", got_half(0), ref_half(2, 0)); end
      checks++; if (got_half(1) !== ref_half(2, 1)) begin errors++; $display("FAIL backpressure_R got %h want %h", got_half(1), ref_half(2, 1)); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL backpressure_latency got %0d want 8", lat); end
   endtask
   task automatic test_start_busy();
      int lat;
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
      clear();
      load(4);
      run(0, 0, 0, 0, 2, 0, lat);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (obsL.size() + obsR.size() !== 4) begin errors++; $display("FAIL busy_strobes got %0d want 4", obsL.size() + obsR.size()); end
      checks++; if (merges !== 1) begin errors++; $display("FAIL busy_merges got %0d want 1", merges); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got %b want 0", busy); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL busy_latency got %0d want 6", lat); end
   endtask
   task automatic test_async_reset();
      int lat;
      bytes = '{8'h03, 8'h07, 8'h01, 8'h09, 8'h00, 8'h00};
      clear();
      load(4);
      start = 1;
      @(posedge clk);
      #1 start = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 0;
      #1;
      checks++; if (array_L !== 8'h00) begin errors++; $display("FAIL areset_array_L got %h want 00", array_L); end
      checks++; if (array_R !== 8'h00) begin errors++; $display("FAIL areset_array_R got %h want 00", array_R); end
      checks++; if (wr_fifo !== 2'b00) begin errors++; $display("FAIL areset_wr_fifo got %b want 00", wr_fifo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
      checks++; if (rd_in !== 1'b0) begin errors++; $display("FAIL areset_rd_in got %b want 0", rd_in); end
      flush = 1;
      @(posedge clk);
      #1 flush = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (merges !== 0) begin errors++; $display("FAIL areset_no_merge got %0d want 0", merges); end
      rst_n = 1;
      bytes = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'h00};
      clear();
      load(4);
      run(0, 0, 0, 0, 0, 0, lat);
      checks++; if (got_half(0) !== ref_half(2, 0)) begin errors++; $display("FAIL areset_L got %h want %h", got_half(0), ref_half(2, 0)); end
      checks++; if (got_half(1) !== ref_half(2, 1)) begin errors++; $display("FAIL areset_R got %h want %h", got_half(1), ref_half(2, 1)); end
      checks++; if (merges !== 1) begin errors++; $display("FAIL areset_merges got %0d want 1", merges); end
   endtask
   task automatic test_random();
      int lat;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
         clear();
         load(4);
         run(0, 0, 0, 0, 0, 1, lat);
         checks++; if (got_half(0) !== ref_half(2, 0)) begin errors++; $display("FAIL random%0d_L got %h want %h", k, got_half(0), ref_half(2, 0)); end
         checks++; if (got_half(1) !== ref_half(2, 1)) begin errors++; $display("FAIL random%0d_R got %h want %h", k, got_half(1), ref_half(2, 1)); end
         checks++; if (merges !== 1 || lat < 6) begin errors++; $display("FAIL random%0d_merge got merges=%0d lat=%0d want merges=1 lat>=6", k, merges, lat); end
         checks++; if (viol !== 0) begin errors++; $display("FAIL random%0d_protocol got %0d want 0", k, viol); end
      end
   endtask
   task automatic test_param3();
      int n = 0, lat = -1;
      bytes = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      clear();
      for (int i = 0; i < 6; i++) begin
         mem3[wp3] = bytes[i];
         wp3 = wp3 + 4'd1;
      end
      start3 = 1;
      while (n < 200) begin
         @(posedge clk);
         n++;
         #1 start3 = 0;
         if (merge3) begin
            lat = n;
            break;
         end
      end
      @(negedge clk);
      #1;
      checks++; if (got_half(0) !== ref_half(3, 0)) begin errors++; $display("FAIL param3_L got %h want %h", got_half(0), ref_half(3, 0)); end
      checks++; if (got_half(1) !== ref_half(3, 1)) begin errors++; $display("FAIL param3_R got %h want %h", got_half(1), ref_half(3, 1)); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL param3_latency got %0d want 8", lat); end
      checks++; if (viol !== 0 || merges !== 1) begin errors++; $display("FAIL param3_protocol got viol=%0d merges=%0d want 0/1", viol, merges); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_backpressure();
      test_start_busy();
      test_async_reset();
      test_random();
      test_param3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
